// File: rtl/sar_result_collector.sv
// Collects SAR conversion results, optionally block-averages 2^n samples and buffers them in a FWFT FIFO.
// Optional min/max tracking of raw samples is built when SAR_COLLECT_MINMAX_EN is defined.
module sar_result_collector #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int AVG_MAX_LOG2 = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [2:0]                      avg_log2,
    input  logic [DATA_W-1:0]               sar_in,
    input  logic                            eoc,
    output logic [DATA_W-1:0]               m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [7:0]                      drop_cnt,
    input  logic                            clr_ovf,
    output logic [DATA_W-1:0]               min_val,
    output logic [DATA_W-1:0]               max_val,
    input  logic                            minmax_clr
);

    localparam int ACC_W = DATA_W + AVG_MAX_LOG2;
    localparam int CNT_W = AVG_MAX_LOG2 + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [2:0]       N_MAX    = 3'(AVG_MAX_LOG2);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Averaging state
    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  blk_cnt_reg;
    logic [2:0]        n_reg;

    logic              sample;
    logic [2:0]        n_clamped;
    logic [2:0]        n_cur;
    logic [CNT_W-1:0]  blk_end;
    logic              blk_last;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] push_data;
    logic              push;

    assign sample    = eoc & enable;
    assign n_clamped = (avg_log2 > N_MAX) ? N_MAX : avg_log2;
    // The exponent only takes effect at a block boundary; mid-block it stays frozen.
    assign n_cur     = (blk_cnt_reg == '0) ? n_clamped : n_reg;
    assign blk_end   = (CNT_W'(1) << n_cur) - CNT_W'(1);
    assign blk_last  = (blk_cnt_reg == blk_end);
    assign sum       = acc_reg + ACC_W'(sar_in);
    assign push_data = DATA_W'(sum >> n_cur);
    assign push      = sample & blk_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= '0;
            blk_cnt_reg <= '0;
            n_reg       <= '0;
        end else if (!enable) begin
            acc_reg     <= '0;
            blk_cnt_reg <= '0;
        end else if (sample) begin
            n_reg <= n_cur;
            if (blk_last) begin
                acc_reg     <= '0;
                blk_cnt_reg <= '0;
            end else begin
                acc_reg     <= sum;
                blk_cnt_reg <= blk_cnt_reg + CNT_W'(1);
            end
        end
    end

    // FIFO storage and control
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [LVL_W-1:0]  level_reg;
    logic [DATA_W-1:0] m_data_reg;
    logic              m_valid_reg;
    logic              overflow_reg;
    logic [7:0]        drop_cnt_reg;

    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    assign pop         = m_valid_reg & m_ready;
    assign full        = (level_reg == LVL_FULL);
    assign wr_en       = push & (~full | pop);
    assign drop        = push & full & ~pop;
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            m_data_reg   <= '0;
            m_valid_reg  <= 1'b0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end

            case ({wr_en, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase

            // Head register: reloaded from memory on pop, or bypassed when the new word becomes head.
            if (pop) begin
                if (level_reg == LVL_W'(1)) begin
                    if (wr_en) begin
                        m_data_reg <= push_data;
                    end else begin
                        m_valid_reg <= 1'b0;
                    end
                end else begin
                    m_data_reg <= mem[rd_ptr_next];
                end
            end else if (wr_en && (level_reg == '0)) begin
                m_data_reg  <= push_data;
                m_valid_reg <= 1'b1;
            end

            if (clr_ovf) begin
                overflow_reg <= 1'b0;
                drop_cnt_reg <= '0;
            end else if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 8'hFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign m_data     = m_data_reg;
    assign m_valid    = m_valid_reg;
    assign fifo_level = level_reg;
    assign overflow   = overflow_reg;
    assign drop_cnt   = drop_cnt_reg;

`ifdef SAR_COLLECT_MINMAX_EN
    logic [DATA_W-1:0] min_reg;
    logic [DATA_W-1:0] max_reg;

    always_ff @(posedge clk) begin
        if (rst || minmax_clr) begin
            min_reg <= '1;
            max_reg <= '0;
        end else if (sample) begin
            if (sar_in < min_reg) begin
                min_reg <= sar_in;
            end
            if (sar_in > max_reg) begin
                max_reg <= sar_in;
            end
        end
    end

    assign min_val = min_reg;
    assign max_val = max_reg;
`else
    logic unused_minmax_clr;
    assign unused_minmax_clr = minmax_clr;
    assign min_val = '1;
    assign max_val = '0;
`endif

endmodule
